// File: rtl/sixteen_input_encoder_pkg.sv
// Shared definitions for the sixteen-input priority drain block.
package sixteen_input_encoder_pkg;

    // Default number of request lines.
    localparam int N_IN_DEFAULT = 16;

    // IDLE: waiting for a capture.
    // DRAIN: emitting captured indices, highest first.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage : sixteen_input_encoder_pkg

// File: rtl/sixteen_input_encoder_priority_encoder.sv
// Combinational highest-index-first priority encoder with an any-set flag.
module priority_encoder #(
    parameter int N_IN  = 16,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scan upward so the most-significant set bit is the last one written.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (req[k]) begin
                idx     = IDX_W'(k);
                any_set = 1'b1;
            end
        end
    end

endmodule : priority_encoder

// File: rtl/sixteen_input_encoder.sv
// Captures a request vector and drains it one index per accepted transfer,
// highest index first, pulsing done after the last index leaves.
//
// Handshake: valid is high for the whole DRAIN state and out holds the
// current index; a transfer happens on each rising edge where valid & ready,
// which clears that index's pending bit. While valid & !ready both out and
// valid hold steady. When valid is low, out reads 0.
//
// busy is the FSM state itself (busy = 1 exactly when in DRAIN).
module sixteen_input_encoder
    import sixteen_input_encoder_pkg::*;
#(
    parameter  int N_IN  = N_IN_DEFAULT,
    localparam int IDX_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic             load,
    input  logic             ready,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t            state;
    state_t            state_d;
    logic [N_IN-1:0]   pending;
    logic [N_IN-1:0]   pending_d;
    logic [N_IN-1:0]   cleared;
    logic              done_q;
    logic              done_d;
    logic [IDX_W-1:0]  top_idx;
    logic              any_set;

    priority_encoder #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_prio (
        .req     (pending),
        .idx     (top_idx),
        .any_set (any_set)
    );

    // Pending with the currently presented index removed.
    always_comb begin
        cleared = pending & ~(N_IN'(1) << top_idx);
    end

    // Next-state logic: capture in IDLE, retire one index per transfer in DRAIN.
    always_comb begin
        state_d   = state;
        pending_d = pending;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    pending_d = in;
                    if (in != '0) begin
                        state_d = DRAIN;
                    end else begin
                        // Empty capture completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // load is deliberately ignored here.
                if (ready) begin
                    pending_d = cleared;
                    if (cleared == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    // State, pending vector and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            done_q  <= done_d;
        end
    end

    // Outputs are decoded straight from registered state, no extra latency.
    always_comb begin
        valid = (state == DRAIN);
        busy  = (state == DRAIN);
        done  = done_q;
        out   = (valid && any_set) ? top_idx : '0;
    end

endmodule : sixteen_input_encoder

// File: tb/tb_sixteen_input_encoder.sv
// Directed bench for sixteen_input_encoder with hand-computed expectations.
module tb_sixteen_input_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic        ready;
    logic [3:0]  out;
    logic        valid;
    logic        busy;
    logic        done;

    int errors;
    int n_checks;

    sixteen_input_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .load  (load),
        .ready (ready),
        .out   (out),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single checking task: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs changed afterwards apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_done);
        check({tag, ".valid"}, valid, 1'b0);
        check({tag, ".busy"},  busy,  1'b0);
        check({tag, ".out"},   out,   4'd0);
        check({tag, ".done"},  done,  exp_done);
    endtask

    task automatic check_drain(input string tag, input logic [3:0] exp_out);
        check({tag, ".valid"}, valid, 1'b1);
        check({tag, ".busy"},  busy,  1'b1);
        check({tag, ".out"},   out,   exp_out);
        check({tag, ".done"},  done,  1'b0);
    endtask

    initial begin
        errors   = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        in       = 16'h0000;
        load     = 1'b0;
        ready    = 1'b0;

        // Reset values hold regardless of clock.
        #3;
        check_idle_outputs("reset_async", 1'b0);
        tick();
        tick();
        check_idle_outputs("reset_clocked", 1'b0);
        rst_n = 1'b1;

        // 8001 drain: 15 then 0, done on the third cycle; first edge after reset honoured.
        in = 16'h8001; load = 1'b1; ready = 1'b1;
        tick();
        check_drain("t1_c1", 4'd15);
        load = 1'b0; in = 16'h0000;
        tick();
        check_drain("t1_c2", 4'd0);
        tick();
        check_idle_outputs("t1_done", 1'b1);
        tick();
        check_idle_outputs("t1_after", 1'b0);

        // Empty load: no valid/busy, done one cycle later only.
        in = 16'h0000; load = 1'b1;
        tick();
        check_idle_outputs("t2_done", 1'b1);
        load = 1'b0;
        tick();
        check_idle_outputs("t2_after", 1'b0);

        // 00F0 with backpressure for three cycles.
        in = 16'h00F0; load = 1'b1; ready = 1'b0;
        tick();
        check_drain("t3_hold1", 4'd7);
        load = 1'b0; in = 16'h0000;
        tick();
        check_drain("t3_hold2", 4'd7);
        tick();
        check_drain("t3_hold3", 4'd7);
        ready = 1'b1;
        tick();
        check_drain("t3_x6", 4'd6);
        tick();
        check_drain("t3_x5", 4'd5);
        tick();
        check_drain("t3_x4", 4'd4);
        tick();
        check_idle_outputs("t3_done", 1'b1);

        // 0003 then a load attempt mid-drain that must be ignored.
        in = 16'h0003; load = 1'b1; ready = 1'b1;
        tick();
        check_drain("t4_c1", 4'd1);
        in = 16'hFFFF; load = 1'b1;
        tick();
        check_drain("t4_c2", 4'd0);
        tick();
        check_idle_outputs("t4_done", 1'b1);
        load = 1'b0; in = 16'h0000;
        tick();
        check_idle_outputs("t4_after", 1'b0);

        // FFFF, reset after five transfers, then a fresh 0400 load.
        in = 16'hFFFF; load = 1'b1; ready = 1'b1;
        tick();
        check_drain("t5_c0", 4'd15);
        load = 1'b0; in = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check({"t5_xfer.out"}, out, 32'(15 - k));
        end
        check_drain("t5_pre_rst", 4'd10);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_in_rst", 1'b0);
        tick();
        check_idle_outputs("t5_rst_clk", 1'b0);
        rst_n = 1'b1;
        tick();
        check_idle_outputs("t5_post_rst", 1'b0);
        in = 16'h0400; load = 1'b1;
        tick();
        check_drain("t5_reload", 4'd10);
        load = 1'b0; in = 16'h0000;
        tick();
        check_idle_outputs("t5_reload_done", 1'b1);

        // 0001 with load held high and in=0002 across the done cycle.
        tick();
        in = 16'h0001; load = 1'b1; ready = 1'b1;
        tick();
        check_drain("t6_c1", 4'd0);
        in = 16'h0002;
        tick();
        check_idle_outputs("t6_done", 1'b1);
        tick();
        check_drain("t6_reload", 4'd1);
        load = 1'b0; in = 16'h0000;
        tick();
        check_idle_outputs("t6_done2", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule : tb_sixteen_input_encoder
